// File: rtl/ad7606_seq_ctrl.sv
// AD7606 parallel-interface sequencer: CONVST, BUSY handshake, N_CH reads, valid/ready out.
// Optional busy-wait timeout enabled with `define ADC_TIMEOUT_EN.
module ad7606_seq_ctrl #(
  parameter int DATA_W       = 16,
  parameter int N_CH         = 8,
  parameter int CONV_LOW     = 4,
  parameter int RD_LOW       = 3,
  parameter int RD_HIGH      = 2,
  parameter int BUSY_TIMEOUT = 1024,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              convst_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int T_A   = (CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW;
  localparam int T_MAX = (T_A > RD_HIGH) ? T_A : RD_HIGH;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_BH,
    WAIT_BL,
    RD_L,
    OUT,
    RD_H,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch;
  logic             busy_meta;
  logic             busy_s;
  logic             conv_last;
  logic             rdl_last;
  logic             rdh_last;
  logic             last_ch;
  logic             tmo_abort;

  assign conv_last = (cnt == CNT_W'(CONV_LOW - 1));
  assign rdl_last  = (cnt == CNT_W'(RD_LOW - 1));
  assign rdh_last  = (cnt == CNT_W'(RD_HIGH - 1));
  assign last_ch   = (ch == CH_W'(N_CH - 1));

  // BUSY comes straight off the ADC pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= adc_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (conv_last) state_nx = WAIT_BH;
      WAIT_BH: begin
        if (busy_s)         state_nx = WAIT_BL;
        else if (tmo_abort) state_nx = IDLE;
      end
      WAIT_BL: begin
        if (!busy_s)        state_nx = RD_L;
        else if (tmo_abort) state_nx = IDLE;
      end
      RD_L:    if (rdl_last) state_nx = OUT;
      OUT: begin
        if (out_ready) state_nx = last_ch ? DONE : RD_H;
      end
      RD_H:    if (rdh_last) state_nx = RD_L;
      DONE:    state_nx = cont ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    convst_n   = 1'b1;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    unique case (1'b1)
      (state == CONV): convst_n = 1'b0;
      (state == RD_L): begin
        cs_n = 1'b0;
        rd_n = 1'b0;
      end
      (state == OUT):  out_valid  = 1'b1;
      (state == DONE): frame_done = 1'b1;
      default: ;
    endcase
  end

  // phase timer restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (state == CONV || state == RD_L || state == RD_H) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
    end else if ((state == IDLE && start) || state == DONE) begin
      ch <= '0;
    end else if (state == OUT && out_ready && !last_ch) begin
      ch <= ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (state == RD_L && rdl_last) begin
      out_data <= adc_data;
      out_ch   <= ch;
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo;
  logic             tmo_hit;
  logic             in_wait;

  assign in_wait   = (state == WAIT_BH) || (state == WAIT_BL);
  assign tmo_hit   = (tmo == TMO_W'(BUSY_TIMEOUT - 1));
  assign tmo_abort = tmo_hit && in_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (state_nx != state) begin
      tmo <= '0;
    end else if (in_wait) begin
      tmo <= tmo + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (state == IDLE && start) begin
      timeout_err <= 1'b0;
    end else if (in_wait && state_nx == IDLE) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/ad7606_seq_ctrl.md
Name: ad7606_seq_ctrl

Overview:
Parametrised multi-channel sequencer for the AD7606 parallel-interface ADC.
- Per frame: pulses CONVST, waits for the ADC BUSY handshake, then reads N_CH channels with programmable RD timing.
- Streams each sample with its channel index over a valid/ready interface.
- Supports single-shot and continuous modes; sits between the ADC pins and downstream sample processing.

Parameters:
DATA_W, 16, sample width
N_CH, 8, channels read per frame (1..8)
CONV_LOW, 4, convst_n low time in clk cycles (>=1)
RD_LOW, 3, rd_n/cs_n low cycles per read (>=1); data sampled on last low cycle
RD_HIGH, 2, rd_n high cycles between reads (>=1)
BUSY_TIMEOUT, 1024, max cycles in either busy-wait state before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
start  in  1  begin frame (single mode) / begin streaming (continuous mode); sampled in IDLE only
cont  in  1  1 = continuous frames until cont deasserted; sampled in IDLE and DONE
adc_busy  in  1  AD7606 BUSY pin, asynchronous
adc_data  in  DATA_W  AD7606 DB bus
convst_n  out  1  conversion start, active low
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
out_data  out  DATA_W  sample
out_ch  out  $clog2(N_CH) (min 1)  channel index of out_data
out_valid  out  1  sample valid
out_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse after last channel accepted
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; convst_n=1, cs_n=1, rd_n=1; out_data=0, out_ch=0, out_valid=0, frame_done=0, busy=0, timeout_err=0; all counters 0. Reset mid-frame aborts immediately with pins released.
- adc_busy passes a 2-flop synchroniser; all decisions use the synchronised value.
- IDLE: on start=1 -> CONV; clears timeout_err; channel counter=0.
- CONV: convst_n=0 for exactly CONV_LOW cycles -> WAIT_BH.
- WAIT_BH: wait for sync busy=1 -> WAIT_BL.
- WAIT_BL: wait for sync busy=0 -> RD_L.
- RD_L: cs_n=0, rd_n=0 for RD_LOW cycles; on the last cycle capture adc_data into out_data and channel counter into out_ch -> OUT.
- OUT: cs_n=1, rd_n=1; out_valid=1, held with out_data/out_ch stable until out_ready=1 (transfer = valid&ready).
  - After transfer, if ch < N_CH-1: ch++ and go to RD_H.
  - If ch = N_CH-1: go to DONE.
- RD_H: rd_n=1, cs_n=1 for RD_HIGH cycles -> RD_L.
- DONE: frame_done=1 for one cycle; if cont=1 -> CONV (ch=0), else -> IDLE.
- Backpressure: no read strobe is issued while out_valid=1; the ADC is never read faster than downstream accepts.
- out_valid drops the cycle after transfer; out_valid never asserts outside OUT.
- N_CH=1: every frame is RD_L -> OUT -> DONE; RD_H is never entered.
- start asserted outside IDLE is ignored. cont dropped mid-frame: current frame completes, then -> IDLE.
- Timeout: cycle counter runs in WAIT_BH/WAIT_BL and resets on entry to each. On reaching BUSY_TIMEOUT: timeout_err=1, all pins released, -> IDLE, no frame_done. timeout_err stays set until the next accepted start or reset.

Optional Feature:
ADC_TIMEOUT_EN
- Defined: timeout logic as described.
- Undefined: busy-wait states wait indefinitely; timeout_err tied to 0; timeout counter not synthesised.

Test Plan:
- Single frame, N_CH=8, out_ready=1, ADC model drives data 16'h1000+ch: convst_n low exactly 4 cycles; 8 beats out_ch 0..7 with data 16'h1000..16'h1007; frame_done one pulse; busy=0 after.
- Backpressure: out_ready low for 10 cycles on ch 3: out_valid/out_data held stable; rd_n stays 1 until accept; ch 4 read strobe begins 2 cycles (RD_HIGH) after accept.
- Continuous mode, 3 frames then cont=0 during frame 3: exactly 24 samples, 3 frame_done pulses, return to IDLE.
- adc_busy stuck low (ADC_TIMEOUT_EN defined, BUSY_TIMEOUT=16): timeout_err=1 after 16 wait cycles, convst_n/cs_n/rd_n=1, no out_valid; next start clears timeout_err.
- Reset asserted during RD_L of ch 5: all outputs return to reset values asynchronously; after release, start yields a full clean frame starting at ch 0.
- N_CH=1, RD_LOW=1: single beat per frame, RD_H never entered, cs_n low exactly 1 cycle.
